// File: rtl/work_loader_pkg.sv
// Shared types and sizing for the work loader: FSM states, section widths and word counts.
package work_loader_pkg;
  localparam int WORD_BITS     = 32;
  localparam int MSG_BITS      = 1944;
  localparam int TGT_BITS      = 256;
  localparam int MSG_WORDS     = 61;
  localparam int TGT_WORDS     = 8;
  localparam int MSG_TAIL_BITS = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_MSG,
    ST_LOAD_TGT,
    ST_PUBLISH,
    ST_HOLD
  } state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction
endpackage

// File: rtl/word_shift_buffer.sv
// Shadow register filled one 32-bit word at a time, MSB-first; the last word may be
// truncated to TAIL_BITS (taken from the top of the word). Exposes its next-cycle value.
module word_shift_buffer #(
  parameter int WIDTH     = 256,
  parameter int WORDS     = 8,
  parameter int TAIL_BITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [5:0]       wr_idx,
  input  logic [31:0]      wr_data,
  output logic [WIDTH-1:0] shadow_next
);
  localparam logic [5:0] LAST_IDX = 6'(WORDS - 1);

  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (clr) begin
      shadow_d = '0;
    end else if (wr_en) begin
      for (int k = 0; k < WORDS - 1; k++) begin
        if (wr_idx == 6'(k)) shadow_d[WIDTH-1-32*k -: 32] = wr_data;
      end
      if (wr_idx == LAST_IDX) shadow_d[TAIL_BITS-1:0] = wr_data[31 -: TAIL_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) shadow_q <= '0;
    else     shadow_q <= shadow_d;
  end

  assign shadow_next = shadow_d;
endmodule

// File: rtl/work_loader.sv
// Streams message/target words into shadows and publishes them atomically with a timed strobe.
// Optional WORK_LOADER_BSWAP_EN byte-reverses every accepted word before storage.
module work_loader
  import work_loader_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_msg,
  input  logic          load_tgt,
  input  logic          abort,
  input  logic          wr_valid,
  input  logic [31:0]   wr_data,
  output logic          wr_ready,
  output logic [1943:0] msg_out,
  output logic [255:0]  target_out,
  output logic          new_msg,
  output logic          new_target,
  output logic          busy,
  output logic [5:0]    word_idx
);
  localparam logic [5:0] MSG_LAST   = 6'(MSG_WORDS - 1);
  localparam logic [5:0] TGT_LAST   = 6'(TGT_WORDS - 1);
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);

  state_e                state_q, state_d;
  logic [5:0]            idx_q, idx_d;
  logic                  pend_tgt_q, pend_tgt_d;
  logic                  ld_msg_q, ld_msg_d;
  logic                  ld_tgt_q, ld_tgt_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [MSG_BITS-1:0]   msg_out_q, msg_out_d;
  logic [TGT_BITS-1:0]   tgt_out_q, tgt_out_d;
  logic                  new_msg_q, new_msg_d;
  logic                  new_tgt_q, new_tgt_d;
  logic                  busy_q, busy_d;
  logic                  wr_ready_q, wr_ready_d;

  logic                  accept, msg_we, tgt_we, clr_shadow;
  logic [31:0]           wdata;
  logic [MSG_BITS-1:0]   msg_next;
  logic [TGT_BITS-1:0]   tgt_next;

`ifdef WORK_LOADER_BSWAP_EN
  assign wdata = bswap32(wr_data);
`else
  assign wdata = wr_data;
`endif

  // wr_ready is registered from the next state, so it always matches state_q.
  assign accept = wr_valid && wr_ready_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pend_tgt_d = pend_tgt_q;
    ld_msg_d   = ld_msg_q;
    ld_tgt_d   = ld_tgt_q;
    cnt_d      = cnt_q;
    new_msg_d  = 1'b0;
    new_tgt_d  = 1'b0;
    msg_we     = 1'b0;
    tgt_we     = 1'b0;
    clr_shadow = 1'b0;
    if (abort) begin
      state_d    = ST_IDLE;
      idx_d      = '0;
      pend_tgt_d = 1'b0;
      ld_msg_d   = 1'b0;
      ld_tgt_d   = 1'b0;
      cnt_d      = '0;
      clr_shadow = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_msg) begin
            state_d    = ST_LOAD_MSG;
            pend_tgt_d = load_tgt;
            ld_msg_d   = 1'b1;
            ld_tgt_d   = load_tgt;
          end else if (load_tgt) begin
            state_d  = ST_LOAD_TGT;
            ld_tgt_d = 1'b1;
          end
        end
        ST_LOAD_MSG: begin
          if (accept) begin
            msg_we = 1'b1;
            if (idx_q == MSG_LAST) begin
              idx_d      = '0;
              pend_tgt_d = 1'b0;
              state_d    = pend_tgt_q ? ST_LOAD_TGT : ST_PUBLISH;
            end else begin
              idx_d = idx_q + 6'd1;
            end
          end
        end
        ST_LOAD_TGT: begin
          if (accept) begin
            tgt_we = 1'b1;
            if (idx_q == TGT_LAST) begin
              idx_d   = '0;
              state_d = ST_PUBLISH;
            end else begin
              idx_d = idx_q + 6'd1;
            end
          end
        end
        ST_PUBLISH: begin
          state_d   = ST_HOLD;
          cnt_d     = '0;
          new_msg_d = ld_msg_q;
          new_tgt_d = ld_tgt_q;
        end
        ST_HOLD: begin
          if (cnt_q == PULSE_LAST) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            ld_msg_d = 1'b0;
            ld_tgt_d = 1'b0;
          end else begin
            cnt_d     = cnt_q + 4'd1;
            new_msg_d = ld_msg_q;
            new_tgt_d = ld_tgt_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are written on the edge into PUBLISH, a full cycle before the strobe rises.
  always_comb begin
    msg_out_d = msg_out_q;
    tgt_out_d = tgt_out_q;
    if (!abort && state_d == ST_PUBLISH && state_q != ST_PUBLISH) begin
      if (ld_msg_q) msg_out_d = msg_next;
      if (ld_tgt_q) tgt_out_d = tgt_next;
    end
    busy_d     = (state_d != ST_IDLE);
    wr_ready_d = (state_d == ST_LOAD_MSG) || (state_d == ST_LOAD_TGT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      pend_tgt_q <= 1'b0;
      ld_msg_q   <= 1'b0;
      ld_tgt_q   <= 1'b0;
      cnt_q      <= '0;
      msg_out_q  <= '0;
      tgt_out_q  <= '0;
      new_msg_q  <= 1'b0;
      new_tgt_q  <= 1'b0;
      busy_q     <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_tgt_q <= pend_tgt_d;
      ld_msg_q   <= ld_msg_d;
      ld_tgt_q   <= ld_tgt_d;
      cnt_q      <= cnt_d;
      msg_out_q  <= msg_out_d;
      tgt_out_q  <= tgt_out_d;
      new_msg_q  <= new_msg_d;
      new_tgt_q  <= new_tgt_d;
      busy_q     <= busy_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  word_shift_buffer #(
    .WIDTH(MSG_BITS), .WORDS(MSG_WORDS), .TAIL_BITS(MSG_TAIL_BITS)
  ) u_msg_buf (
    .clk(clk), .rst(rst), .clr(clr_shadow), .wr_en(msg_we),
    .wr_idx(idx_q), .wr_data(wdata), .shadow_next(msg_next)
  );

  word_shift_buffer #(
    .WIDTH(TGT_BITS), .WORDS(TGT_WORDS), .TAIL_BITS(WORD_BITS)
  ) u_tgt_buf (
    .clk(clk), .rst(rst), .clr(clr_shadow), .wr_en(tgt_we),
    .wr_idx(idx_q), .wr_data(wdata), .shadow_next(tgt_next)
  );

  assign wr_ready   = wr_ready_q;
  assign msg_out    = msg_out_q;
  assign target_out = tgt_out_q;
  assign new_msg    = new_msg_q;
  assign new_target = new_tgt_q;
  assign busy       = busy_q;
  assign word_idx   = idx_q;
endmodule

// File: tb/tb_work_loader.sv
// Directed bench for work_loader: queued expected words are folded into a reference
// copy of the published outputs at each publish, then compared slice by slice.
module tb_work_loader;
  localparam int PULSE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_msg = 1'b0;
  logic          load_tgt = 1'b0;
  logic          abort = 1'b0;
  logic          wr_valid = 1'b0;
  logic [31:0]   wr_data = '0;
  logic          wr_ready;
  logic [1943:0] msg_out;
  logic [255:0]  target_out;
  logic          new_msg;
  logic          new_target;
  logic          busy;
  logic [5:0]    word_idx;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;

  logic [31:0]   exp_msg_q[$];
  logic [31:0]   exp_tgt_q[$];
  logic [1943:0] exp_msg = '0;
  logic [255:0]  exp_tgt = '0;

  work_loader #(.PULSE_CYCLES(PULSE)) dut (
    .clk(clk), .rst(rst), .load_msg(load_msg), .load_tgt(load_tgt), .abort(abort),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .msg_out(msg_out), .target_out(target_out), .new_msg(new_msg),
    .new_target(new_target), .busy(busy), .word_idx(word_idx)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    if (!rst && !abort && wr_valid && wr_ready) acc_cnt <= acc_cnt + 1;
  end

  function automatic logic [31:0] model_word(input logic [31:0] d);
`ifdef WORK_LOADER_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_word(input logic [31:0] d);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    while (!wr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 256'(n < 50), 256'(1));
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic msg_word(input logic [31:0] d);
    exp_msg_q.push_back(model_word(d));
    send_word(d);
  endtask

  task automatic tgt_word(input logic [31:0] d);
    exp_tgt_q.push_back(model_word(d));
    send_word(d);
  endtask

  task automatic request(input logic m, input logic t);
    load_msg = m;
    load_tgt = t;
    @(negedge clk);
    load_msg = 1'b0;
    load_tgt = 1'b0;
  endtask

  // scoreboard: pop queued words into the reference outputs
  task automatic publish_model(input bit m, input bit t);
    logic [31:0] w;
    if (m) begin
      check("msg_q_depth", 256'(exp_msg_q.size()), 256'(61));
      for (int k = 0; k < 61 && exp_msg_q.size() > 0; k++) begin
        w = exp_msg_q.pop_front();
        if (k < 60) exp_msg[1943-32*k -: 32] = w;
        else        exp_msg[23:0] = w[31:8];
      end
    end
    if (t) begin
      check("tgt_q_depth", 256'(exp_tgt_q.size()), 256'(8));
      for (int k = 0; k < 8 && exp_tgt_q.size() > 0; k++) begin
        w = exp_tgt_q.pop_front();
        exp_tgt[255-32*k -: 32] = w;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_msg%0d", tag, i), 256'(msg_out[i*243 +: 243]), 256'(exp_msg[i*243 +: 243]));
    check({tag, "_tgt"}, target_out, exp_tgt);
  endtask

  // Called in the PUBLISH cycle (one cycle after the last accept).
  task automatic watch_strobes(input string tag, input bit m, input bit t);
    check({tag, "_pub_new_msg"}, 256'(new_msg), 256'(0));
    check({tag, "_pub_new_tgt"}, 256'(new_target), 256'(0));
    check({tag, "_pub_busy"}, 256'(busy), 256'(1));
    for (int i = 0; i < PULSE + 2; i++) begin
      @(negedge clk);
      check($sformatf("%s_new_msg_c%0d", tag, i), 256'(new_msg), 256'(m && i < PULSE));
      check($sformatf("%s_new_tgt_c%0d", tag, i), 256'(new_target), 256'(t && i < PULSE));
      check($sformatf("%s_busy_c%0d", tag, i), 256'(busy), 256'(i < PULSE));
      check($sformatf("%s_idx_c%0d", tag, i), 256'(word_idx), 256'(0));
    end
  endtask

  initial begin
    int acc0;
    logic [31:0] w;

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_ready", 256'(wr_ready), 256'(0));
    check("rst_new_msg", 256'(new_msg), 256'(0));
    check("rst_new_tgt", 256'(new_target), 256'(0));
    check("rst_idx", 256'(word_idx), 256'(0));
    check_outputs("rst");

    // wr_valid in IDLE is ignored
    wr_valid = 1'b1; wr_data = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    wr_valid = 1'b0;
    check("idle_valid_busy", 256'(busy), 256'(0));
    check("idle_valid_acc", 256'(acc_cnt), 256'(0));

    // target only; a load_msg mid-load must be ignored
    request(1'b0, 1'b1);
    check("tgt_busy", 256'(busy), 256'(1));
    check("tgt_ready", 256'(wr_ready), 256'(1));
    tgt_word(32'h0000_0000);
    tgt_word(32'h0000_FFFF);
    tgt_word(32'hFFFF_FFFF);
    request(1'b1, 1'b0);
    check("tgt_idx3", 256'(word_idx), 256'(3));
    for (int k = 3; k < 8; k++) tgt_word(32'hFFFF_FFFF);
    publish_model(1'b0, 1'b1);
    check_outputs("tgt");
`ifndef WORK_LOADER_BSWAP_EN
    check("tgt_const", target_out, {64'h00000000_0000FFFF, {192{1'b1}}});
`endif
    watch_strobes("tgt", 1'b0, 1'b1);

    // message only
    request(1'b1, 1'b0);
    for (int k = 0; k < 60; k++) begin
      if (k == 30) check("msg_idx30", 256'(word_idx), 256'(30));
      msg_word(32'h0100_0000 + 32'(k));
    end
    check("msg_idx60", 256'(word_idx), 256'(60));
    msg_word(32'hAABB_CCDD);
    publish_model(1'b1, 1'b0);
    check_outputs("msg");
`ifndef WORK_LOADER_BSWAP_EN
    check("msg_tail", 256'(msg_out[23:0]), 256'(24'hAABBCC));
    check("msg_head", 256'(msg_out[1943:1912]), 256'(32'h0100_0000));
`endif
    watch_strobes("msg", 1'b1, 1'b0);

    // both requests, valid stalls every other cycle
    acc0 = acc_cnt;
    request(1'b1, 1'b1);
    for (int k = 0; k < 61; k++) begin
      msg_word($urandom);
      @(negedge clk);
    end
    check("both_mid_busy", 256'(busy), 256'(1));
    check("both_mid_idx", 256'(word_idx), 256'(0));
    check("both_mid_new_msg", 256'(new_msg), 256'(0));
    for (int k = 0; k < 7; k++) begin
      tgt_word($urandom);
      @(negedge clk);
    end
    tgt_word($urandom);
    check("both_accepts", 256'(acc_cnt - acc0), 256'(69));
    publish_model(1'b1, 1'b1);
    check_outputs("both");
    watch_strobes("both", 1'b1, 1'b1);

    // abort after 30 message words, with a valid word in the abort cycle
    request(1'b1, 1'b0);
    for (int k = 0; k < 30; k++) send_word($urandom);
    acc0 = acc_cnt;
    abort = 1'b1; wr_valid = 1'b1; wr_data = 32'h1234_5678;
    @(negedge clk);
    abort = 1'b0; wr_valid = 1'b0;
    check("abort_busy", 256'(busy), 256'(0));
    check("abort_ready", 256'(wr_ready), 256'(0));
    check("abort_idx", 256'(word_idx), 256'(0));
    check("abort_no_accept", 256'(acc_cnt - acc0), 256'(0));
    repeat (3) begin
      @(negedge clk);
      check("abort_no_strobe", 256'({new_msg, new_target}), 256'(0));
    end
    check_outputs("abort_hold");
    request(1'b1, 1'b0);
    for (int k = 0; k < 61; k++) msg_word(32'hC0DE_0000 ^ 32'(k * 7));
    publish_model(1'b1, 1'b0);
    check_outputs("after_abort");
    watch_strobes("after_abort", 1'b1, 1'b0);

    // target with byte-order probe, then abort during HOLD
    request(1'b0, 1'b1);
    tgt_word(32'h1122_3344);
    for (int k = 1; k < 8; k++) tgt_word($urandom);
    publish_model(1'b0, 1'b1);
    check_outputs("hold_abort");
`ifdef WORK_LOADER_BSWAP_EN
    check("bswap_word0", 256'(target_out[255:224]), 256'(32'h4433_2211));
`else
    check("plain_word0", 256'(target_out[255:224]), 256'(32'h1122_3344));
`endif
    @(negedge clk);
    check("hold_abort_strobe_on", 256'(new_target), 256'(1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("hold_abort_strobe_off", 256'(new_target), 256'(0));
    check("hold_abort_busy", 256'(busy), 256'(0));
    check_outputs("hold_abort_kept");

    // load request during HOLD is not queued
    request(1'b0, 1'b1);
    for (int k = 0; k < 8; k++) tgt_word($urandom);
    publish_model(1'b0, 1'b1);
    @(negedge clk);
    request(1'b1, 1'b1);
    check("hold_req_strobe", 256'(new_target), 256'(1));
    repeat (3) begin
      @(negedge clk);
      check("hold_req_ignored", 256'(busy), 256'(0));
    end

    // reset asserted mid-HOLD
    request(1'b1, 1'b0);
    for (int k = 0; k < 61; k++) msg_word($urandom);
    publish_model(1'b1, 1'b0);
    check_outputs("pre_reset");
    @(negedge clk);
    check("pre_reset_strobe", 256'(new_msg), 256'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_msg = '0;
    exp_tgt = '0;
    check("reset_hold_busy", 256'(busy), 256'(0));
    check("reset_hold_strobes", 256'({new_msg, new_target}), 256'(0));
    check("reset_hold_ready", 256'(wr_ready), 256'(0));
    check_outputs("reset_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/work_loader.md
Name: work_loader

Overview:
- Upstream feeder for the miner top level.
- Accepts 32-bit words over a valid/ready stream and assembles them into shadow buffers: 1944-bit block-header message (61 words) and 256-bit target (8 words).
- Copies completed shadows atomically to its output registers, then holds new_msg / new_target high for a fixed number of cycles. The miner's rising-edge detectors see one clean edge per load.
- Lets software stream work without the miner ever seeing a partially written message or target.

Parameters:
- PULSE_CYCLES, 2, cycles new_msg/new_target stay high after publish (legal range 1..15).
- MSG_WORDS, 61, message words; last word contributes only its upper 24 bits. Fixed; derived from package.
- TGT_WORDS, 8, target words. Fixed; derived from package.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- load_msg  in  1  request message load; sampled in IDLE only.
- load_tgt  in  1  request target load; sampled in IDLE only.
- abort  in  1  cancel any load in progress.
- wr_valid  in  1  word valid.
- wr_data  in  32  word payload.
- wr_ready  out  1  word accepted when wr_valid && wr_ready.
- msg_out  out  1944  published message, feeds miner inputMsg.
- target_out  out  256  published target, feeds miner inputTarget.
- new_msg  out  1  level pulse, PULSE_CYCLES long.
- new_target  out  1  level pulse, PULSE_CYCLES long.
- busy  out  1  high in any state other than IDLE.
- word_idx  out  6  index of next expected word within the current section.

Behaviour:
- Reset (synchronous): state IDLE; all outputs 0; shadows 0; pending flags 0.
- States: IDLE, LOAD_MSG, LOAD_TGT, PUBLISH, HOLD.
- IDLE:
  - wr_ready=0.
  - load_msg → LOAD_MSG. If load_tgt is also high, set pend_tgt.
  - load_tgt alone → LOAD_TGT.
  - Neither → stay in IDLE.
  - Both requests in the same cycle = message then target.
- LOAD_MSG:
  - wr_ready=1.
  - Word k (k=0..59) → msg_shadow[1943-32k -: 32].
  - Word 60: wr_data[31:8] → msg_shadow[23:0]; wr_data[7:0] discarded.
  - After word 60 is accepted: go to LOAD_TGT if pend_tgt, else PUBLISH. word_idx resets to 0.
- LOAD_TGT:
  - wr_ready=1.
  - Word k (k=0..7) → tgt_shadow[255-32k -: 32].
  - After word 7 → PUBLISH.
- PUBLISH:
  - Lasts exactly one cycle; wr_ready=0.
  - Copies only the loaded sections' shadows into msg_out / target_out. Unloaded outputs are unchanged.
  - → HOLD.
- HOLD:
  - new_msg (if a message was loaded) and/or new_target (if a target was loaded) are high for exactly PULSE_CYCLES cycles, via a 4-bit counter.
  - Then → IDLE. Both strobes are low in IDLE.
- Latency: the published data is stable one cycle before the strobe rises. The first high strobe cycle is 2 cycles after the final accepted word.
- wr_valid outside the LOAD states: ignored; no state change.
- load_msg / load_tgt outside IDLE: ignored; not queued.
- abort:
  - Any state → IDLE next cycle; priority over word acceptance in the same cycle.
  - Shadows and pending flags cleared. Published outputs are not modified.
  - Abort in HOLD drops the strobes immediately.
- Back-to-back: a new request in the first IDLE cycle is legal. The strobe is guaranteed ≥1 low cycle between loads.
- word_idx: in LOAD_MSG, 0..60; in LOAD_TGT, 0..7; 0 in every other state. It never wraps past the section end.

Optional Feature:
- Macro: WORK_LOADER_BSWAP_EN.
- Defined: every accepted wr_data is byte-reversed before storage: {d[7:0],d[15:8],d[23:16],d[31:24]}. This matches the little-endian Bitcoin header layout. The message word-60 truncation applies after the swap.
- Undefined: words are stored as received.

Decomposition:
- Package work_loader_pkg holds:
  - state enum;
  - MSG_BITS=1944, TGT_BITS=256, MSG_WORDS=61, TGT_WORDS=8;
  - MSG_TAIL_BITS=24.
- One natural sub-module: word_shift_buffer, parameterised width and word count. It is a shadow register with a word-indexed write, instanced once for the message and once for the target.
- FSM, pulse counter and publish logic stay in work_loader.

Test Plan:
- Target only: load_tgt, 8 words 0x00000000,0x0000FFFF,0xFFFFFFFF×6 → target_out=0x00000000_0000FFFF_FF…FF; new_target high exactly 2 cycles; new_msg stays 0; msg_out unchanged.
- Message only: 61 words, word k = 0x01000000+k, last word 0xAABBCCDD → msg_out[23:0]=0xAABBCC; msg_out[1943:1912]=0x01000000; new_msg rises 2 cycles after the last accept.
- Both requests in the same cycle with wr_valid stalls (valid low every other cycle) → 69 accepts total; one PUBLISH; new_msg and new_target rise in the same cycle.
- Abort after 30 message words → busy=0 next cycle; msg_out still holds the prior value; no strobe. A subsequent full load publishes only the new data.
- Reset asserted mid-HOLD → all outputs 0 next cycle; load requests in non-IDLE states produce no effect.
- With WORK_LOADER_BSWAP_EN: target word 0x11223344 → stored as 0x44332211.
